// File: rtl/spi_ram_arb_pkg.sv
// Shared types and constants for the SPI/host RAM sequencer.
// Holds the sequencer state encoding, the SPI opcode values carried in
// rx_data[9:8] and the requester ids used by the round-robin arbiter.
package spi_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACC_SPI  = 2'd1,
        ACC_HOST = 2'd2,
        RD_WAIT  = 2'd3
    } arb_state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // Requester ids double as bit positions in the arbiter req/gnt vectors.
    localparam logic REQ_SPI  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter.
// A lone requester always wins; on a tie the requester that did not win
// last time is granted. last_gnt only moves when advance is high, so the
// grant stays stable while the sequencer is busy.
module rr_arb2
    import spi_ram_arb_pkg::*;
(
    input  logic       CLK,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_gnt;

    // Pick the winner: pass a single request through, alternate on ties.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = 2'b00;
            if (last_gnt == REQ_HOST) begin
                gnt[REQ_SPI] = 1'b1;
            end else begin
                gnt[REQ_HOST] = 1'b1;
            end
        end
    end

    // Remember who won; starting at host lets SPI take the first tie.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= REQ_HOST;
        end else if (advance && (gnt != 2'b00)) begin
            last_gnt <= gnt[REQ_HOST];
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Sequencer between the SPI slave word interface, a local host port and a
// single-port RAM with registered read data.
// Optional feature macro: SPI_ADDR_AUTOINC_EN -- when defined, the SPI write
// and read address registers step (wrapping at MEM_DEPTH-1) after each SPI
// data write / data read. When undefined they change only on address loads.
module spi_ram_arbiter
    import spi_ram_arb_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [9:0]           rx_data,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [7:0]           host_rdata,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata,
    output logic                 spi_ovr
);

    if (MEM_DEPTH != (2 ** ADDR_SIZE)) begin : g_depth_check
        $error("spi_ram_arbiter: MEM_DEPTH must equal 2**ADDR_SIZE");
    end

    arb_state_t           state, next_state;
    logic                 rx_valid_q;
    logic                 rx_rise;
    logic [1:0]           rx_op;
    logic [7:0]           rx_payload;
    logic                 rx_is_data;
    logic                 spi_new;
    logic                 spi_pend;
    logic                 spi_is_rd;
    logic [7:0]           spi_payload;
    logic                 spi_ovr_q;
    logic [ADDR_SIZE-1:0] spi_wr_addr;
    logic [ADDR_SIZE-1:0] spi_rd_addr;
    logic                 rd_is_host;
    logic [7:0]           tx_data_q;
    logic [7:0]           host_rdata_q;
    logic                 in_idle;
    logic [1:0]           arb_req;
    logic [1:0]           arb_gnt;

`ifdef SPI_ADDR_AUTOINC_EN
    function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
        return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + ADDR_SIZE'(1);
    endfunction
`endif

    assign rx_rise    = rx_valid & ~rx_valid_q;
    assign rx_op      = rx_data[9:8];
    assign rx_payload = rx_data[7:0];
    assign rx_is_data = (rx_op == OP_WR_DATA) || (rx_op == OP_RD_DATA);

    // A fresh data word arriving in IDLE competes in the same cycle it is
    // captured, so an uncontested access follows the edge by one cycle.
    assign spi_new = rx_rise & rx_is_data & ~spi_pend;
    assign in_idle = (state == IDLE);

    assign arb_req[REQ_SPI]  = in_idle & (spi_pend | spi_new);
    assign arb_req[REQ_HOST] = in_idle & host_req;

    rr_arb2 u_arb (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (in_idle),
        .gnt     (arb_gnt)
    );

    // SPI word capture: address loads, pending data command and overrun.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q  <= 1'b0;
            spi_pend    <= 1'b0;
            spi_is_rd   <= 1'b0;
            spi_payload <= '0;
            spi_ovr_q   <= 1'b0;
            spi_wr_addr <= '0;
            spi_rd_addr <= '0;
        end else begin
            rx_valid_q <= rx_valid;
            if (state == ACC_SPI) begin
                spi_pend <= 1'b0;
`ifdef SPI_ADDR_AUTOINC_EN
                if (spi_is_rd) begin
                    spi_rd_addr <= addr_inc(spi_rd_addr);
                end else begin
                    spi_wr_addr <= addr_inc(spi_wr_addr);
                end
`endif
            end
            if (rx_rise) begin
                case (rx_op)
                    OP_WR_ADDR: spi_wr_addr <= ADDR_SIZE'(rx_payload);
                    OP_RD_ADDR: spi_rd_addr <= ADDR_SIZE'(rx_payload);
                    default: begin
                        if (spi_pend) begin
                            spi_ovr_q <= 1'b1;
                        end else begin
                            spi_pend    <= 1'b1;
                            spi_is_rd   <= (rx_op == OP_RD_DATA);
                            spi_payload <= rx_payload;
                        end
                    end
                endcase
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: grant in IDLE, reads take an extra RD_WAIT cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (arb_gnt[REQ_SPI]) begin
                    next_state = ACC_SPI;
                end else if (arb_gnt[REQ_HOST]) begin
                    next_state = ACC_HOST;
                end
            end
            ACC_SPI:  next_state = spi_is_rd ? RD_WAIT : IDLE;
            ACC_HOST: next_state = host_we ? IDLE : RD_WAIT;
            RD_WAIT:  next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Read ownership and held read-data copies for the two requesters.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rd_is_host   <= 1'b0;
            tx_data_q    <= '0;
            host_rdata_q <= '0;
        end else begin
            if (state == ACC_SPI) begin
                rd_is_host <= 1'b0;
            end else if (state == ACC_HOST) begin
                rd_is_host <= 1'b1;
            end
            if (state == RD_WAIT) begin
                if (rd_is_host) begin
                    host_rdata_q <= ram_rdata;
                end else begin
                    tx_data_q <= ram_rdata;
                end
            end
        end
    end

    // Output decode: RAM port only driven in ACC states, read data bypassed
    // straight from the RAM in RD_WAIT and held afterwards.
    always_comb begin
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        host_gnt    = 1'b0;
        tx_valid    = 1'b0;
        host_rvalid = 1'b0;
        tx_data     = tx_data_q;
        host_rdata  = host_rdata_q;
        spi_ovr     = spi_ovr_q;
        case (state)
            ACC_SPI: begin
                ram_en    = 1'b1;
                ram_we    = ~spi_is_rd;
                ram_addr  = spi_is_rd ? spi_rd_addr : spi_wr_addr;
                ram_wdata = spi_is_rd ? 8'h00 : spi_payload;
            end
            ACC_HOST: begin
                ram_en    = 1'b1;
                ram_we    = host_we;
                ram_addr  = host_addr;
                ram_wdata = host_wdata;
                host_gnt  = 1'b1;
            end
            RD_WAIT: begin
                if (rd_is_host) begin
                    host_rvalid = 1'b1;
                    host_rdata  = ram_rdata;
                end else begin
                    tx_valid = 1'b1;
                    tx_data  = ram_rdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed self-checking bench for spi_ram_arbiter with a behavioural
// single-port RAM (registered read data) attached to the RAM port.
module tb_spi_ram_arbiter;

    typedef struct packed {
        int         cyc;
        logic       host;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } acc_t;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [9:0] rx_data = '0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_gnt;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic       spi_ovr;

    logic [7:0] mem [256] = '{default: 8'h00};
    int         cyc = 0;
    int         checkCount = 0;
    int         passCount = 0;

    acc_t       accLog[$];
    int         txCyc[$];
    logic [7:0] txDat[$];
    int         hrCyc[$];
    logic [7:0] hrDat[$];

    spi_ram_arbiter #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .spi_ovr     (spi_ovr)
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    // Cycle counter used to timestamp observed events.
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural RAM: synchronous write, registered read data.
    always @(posedge CLK) begin
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
    end

    // Monitor on the falling edge: log RAM accesses and read-data pulses.
    always @(negedge CLK) begin
        if (ram_en) accLog.push_back(acc_t'{cyc, host_gnt, ram_we, ram_addr, ram_wdata});
        if (tx_valid) begin
            txCyc.push_back(cyc);
            txDat.push_back(tx_data);
        end
        if (host_rvalid) begin
            hrCyc.push_back(cyc);
            hrDat.push_back(host_rdata);
        end
    end

    // Hard stop if anything ever hangs.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic acc_t getAcc(input int i);
        acc_t e;
        e = '0;
        if (i < accLog.size()) e = accLog[i];
        return e;
    endfunction

    function automatic logic [63:0] allOutputs();
        return {26'd0, ram_en, ram_we, ram_addr, ram_wdata, tx_valid, tx_data,
                host_gnt, host_rvalid, host_rdata, spi_ovr};
    endfunction

    task automatic clearLogs();
        accLog.delete();
        txCyc.delete();
        txDat.delete();
        hrCyc.delete();
        hrDat.delete();
    endtask

    // One SPI word: rx_valid high for 3 cycles, then low for 2.
    task automatic applyStimulus(input logic [9:0] w, output int riseCyc);
        @(posedge CLK);
        #1;
        rx_data  = w;
        rx_valid = 1'b1;
        riseCyc  = cyc;
        repeat (3) @(posedge CLK);
        #1 rx_valid = 1'b0;
        repeat (2) @(posedge CLK);
    endtask

    // Host access: hold the request until the grant pulse, bounded wait.
    task automatic hostRequest(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        bit seen;
        seen = 1'b0;
        @(posedge CLK);
        #1;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (host_gnt) seen = 1'b1;
        end
        if (!seen) checkOutput("host_gnt_timeout", 0, 1);
        @(posedge CLK);
        #1 host_req = 1'b0;
    endtask

    task automatic doReset();
        #1;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        host_req = 1'b0;
        repeat (2) @(posedge CLK);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge CLK);
    endtask

    initial begin
        int   rc;
        int   riseQ[3];
        int   spiCyc[3];
        int   spiSeen;
        int   hostSeen;
        int   hostBetween;
        int   txBefore;
        acc_t e;

        // Reset state
        repeat (2) @(posedge CLK);
        #1 checkOutput("reset_outputs", allOutputs(), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge CLK);

        // Address load then single SPI write of A5 to 05
        clearLogs();
        applyStimulus(10'h005, rc);
        checkOutput("wraddr_no_access", accLog.size(), 0);
        applyStimulus(10'h1A5, rc);
        e = getAcc(0);
        checkOutput("wr_count", accLog.size(), 1);
        checkOutput("wr_fields", {e.host, e.we, e.addr, e.data}, {1'b0, 1'b1, 8'h05, 8'hA5});
        checkOutput("wr_latency", e.cyc, rc + 1);
        checkOutput("wr_mem05", mem[8'h05], 8'hA5);

        // SPI read of 05
        clearLogs();
        applyStimulus(10'h205, rc);
        applyStimulus(10'h300, rc);
        e = getAcc(0);
        checkOutput("rd_count", accLog.size(), 1);
        checkOutput("rd_fields", {e.host, e.we, e.addr}, {1'b0, 1'b0, 8'h05});
        checkOutput("rd_acc_cycle", e.cyc, rc + 1);
        checkOutput("rd_tx_count", txCyc.size(), 1);
        checkOutput("rd_tx_cycle", (txCyc.size() > 0) ? txCyc[0] : -1, rc + 2);
        checkOutput("rd_tx_data", (txDat.size() > 0) ? txDat[0] : 8'hXX, 8'hA5);
        checkOutput("rd_tx_held", tx_data, 8'hA5);

        // Tie from reset: SPI write C3 to 05 and host read of 05 together
        doReset();
        applyStimulus(10'h005, rc);
        clearLogs();
        fork
            applyStimulus(10'h1C3, rc);
            hostRequest(1'b0, 8'h05, 8'h00);
        join
        repeat (4) @(posedge CLK);
        e = getAcc(0);
        checkOutput("tie_spi_first", {e.host, e.we, e.addr, e.data}, {1'b0, 1'b1, 8'h05, 8'hC3});
        checkOutput("tie_spi_cycle", e.cyc, rc + 1);
        e = getAcc(1);
        checkOutput("tie_host_second", {e.host, e.we, e.addr}, {1'b1, 1'b0, 8'h05});
        checkOutput("tie_host_cycle", e.cyc, rc + 3);
        checkOutput("tie_rvalid_count", hrCyc.size(), 1);
        checkOutput("tie_rvalid_cycle", (hrCyc.size() > 0) ? hrCyc[0] : -1, rc + 4);
        checkOutput("tie_rdata", (hrDat.size() > 0) ? hrDat[0] : 8'hXX, 8'hC3);

        // Host held continuously against an SPI read stream
        clearLogs();
        host_we   = 1'b0;
        host_addr = 8'h10;
        host_req  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(10'h205, rc);
            applyStimulus(10'h300, rc);
            riseQ[k] = rc;
        end
        repeat (4) @(posedge CLK);
        #1 host_req = 1'b0;
        repeat (6) @(posedge CLK);
        spiSeen  = 0;
        hostSeen = 0;
        foreach (accLog[i]) begin
            if (accLog[i].host) begin
                hostSeen++;
            end else begin
                if (spiSeen < 3) spiCyc[spiSeen] = accLog[i].cyc;
                spiSeen++;
            end
        end
        checkOutput("rr_spi_count", spiSeen, 3);
        checkOutput("rr_host_served", hostSeen >= 3, 1);
        for (int k = 0; k < 3; k++) begin
            hostBetween = 0;
            foreach (accLog[i]) begin
                if (accLog[i].host && accLog[i].cyc > riseQ[k] && accLog[i].cyc < spiCyc[k]) hostBetween++;
            end
            checkOutput($sformatf("rr_wait%0d", k), hostBetween <= 1, 1);
            checkOutput($sformatf("rr_latency%0d", k), (spiCyc[k] - riseQ[k]) <= 4, 1);
        end
        checkOutput("rr_tx_count", txDat.size(), 3);
        checkOutput("rr_tx_data", (txDat.size() > 2) ? txDat[2] : 8'hXX, 8'hC3);
        checkOutput("rr_host_rdata", (hrDat.size() > 0) ? hrDat[0] : 8'hXX, 8'h00);
        checkOutput("rr_no_ovr", spi_ovr, 1'b0);

        // Overrun: two data words while a host read holds the RAM
        applyStimulus(10'h020, rc);
        clearLogs();
        @(posedge CLK);
        #1;
        host_we   = 1'b0;
        host_addr = 8'h10;
        host_req  = 1'b1;
        @(posedge CLK);
        #1;
        host_req = 1'b0;
        rx_data  = 10'h111;
        rx_valid = 1'b1;
        rc       = cyc;
        @(posedge CLK);
        #1 rx_valid = 1'b0;
        @(posedge CLK);
        #1;
        rx_data  = 10'h122;
        rx_valid = 1'b1;
        repeat (3) @(posedge CLK);
        #1 rx_valid = 1'b0;
        repeat (5) @(posedge CLK);
        checkOutput("ovr_flag", spi_ovr, 1'b1);
        checkOutput("ovr_acc_count", accLog.size(), 2);
        e = getAcc(0);
        checkOutput("ovr_host_first", {e.host, e.we, e.addr}, {1'b1, 1'b0, 8'h10});
        e = getAcc(1);
        checkOutput("ovr_spi_write", {e.host, e.we, e.addr, e.data}, {1'b0, 1'b1, 8'h20, 8'h11});
        checkOutput("ovr_spi_cycle", e.cyc, rc + 3);
        checkOutput("ovr_mem20", mem[8'h20], 8'h11);

        // Address wrap behaviour around FF
        applyStimulus(10'h0FF, rc);
        applyStimulus(10'h1AA, rc);
        applyStimulus(10'h1BB, rc);
`ifdef SPI_ADDR_AUTOINC_EN
        checkOutput("inc_memFF", mem[8'hFF], 8'hAA);
        checkOutput("inc_mem00", mem[8'h00], 8'hBB);
`else
        checkOutput("noinc_memFF", mem[8'hFF], 8'hBB);
        checkOutput("noinc_mem00", mem[8'h00], 8'h00);
`endif
        checkOutput("ovr_sticky", spi_ovr, 1'b1);

        // Reset asserted during RD_WAIT of an SPI read
        applyStimulus(10'h2FF, rc);
        clearLogs();
        txBefore = txCyc.size();
        @(posedge CLK);
        #1;
        rx_data  = 10'h300;
        rx_valid = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #2 rst_n = 1'b0;
        #1 checkOutput("rst_mid_outputs", allOutputs(), 64'd0);
        rx_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        e = getAcc(0);
        checkOutput("rst_read_issued", {e.we, e.addr}, {1'b0, 8'hFF});
        checkOutput("rst_no_tx", txCyc.size(), txBefore);
        checkOutput("rst_post_outputs", allOutputs(), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Sequencer between the SPI slave's 10-bit command/data interface and the single-port RAM. Decodes SPI command words into RAM address loads, writes and reads, and shares the RAM port with a second local host requester under round-robin arbitration. Returns SPI read data via the `tx_valid`/`tx_data` handshake the SPI slave consumes.

## Interface
- `MEM_DEPTH`, 256: RAM words.
- `ADDR_SIZE`, 8: RAM address width; `MEM_DEPTH` must equal 2**`ADDR_SIZE`.
- `CLK`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_valid`  in  1  SPI word valid; level signal, may stay high many cycles.
- `rx_data`  in  10  SPI word.
  - [9:8] opcode: 00 = write-address, 01 = write-data, 10 = read-address, 11 = read-data.
  - [7:0] payload.
- `tx_valid`  out  1  one-cycle pulse, SPI read data valid.
- `tx_data`  out  8  SPI read data; held until the next SPI read completes.
- `host_req`  in  1  host access request; held until granted.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  `ADDR_SIZE`  host address.
- `host_wdata`  in  8  host write data.
- `host_gnt`  out  1  one-cycle pulse in the cycle the host access drives the RAM.
- `host_rvalid`  out  1  one-cycle pulse, host read data valid.
- `host_rdata`  out  8  host read data; held until the next host read completes.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  `ADDR_SIZE`  RAM address.
- `ram_wdata`  out  8  RAM write data.
- `ram_rdata`  in  8  RAM read data; registered, valid one cycle after `ram_en` with `ram_we`=0.
- `spi_ovr`  out  1  sticky SPI overrun flag; cleared only by reset.

## Operation
- SPI capture: a rising edge of `rx_valid` (registered edge detector) latches `rx_data`.
  - Opcodes 00 and 10 load `spi_wr_addr` / `spi_rd_addr` directly. No RAM access.
  - Opcodes 01 and 11 set `spi_pend` together with the opcode and payload.
  - A rising edge while `spi_pend`=1 is dropped and sets `spi_ovr`.
- Host request: `host_req`=1 while the FSM is in IDLE makes the host a candidate.
- FSM states: IDLE, ACC_SPI, ACC_HOST, RD_WAIT.
  - IDLE → ACC_SPI or ACC_HOST when any candidate exists.
  - ACC_* → RD_WAIT for reads, → IDLE for writes.
  - RD_WAIT → IDLE.
- Arbitration: 2-way round-robin. The last winner is recorded in `last_gnt`; reset value = host, so SPI wins the first tie.
- ACC_SPI drives `ram_en`=1 with one of:
  - opcode 01: `ram_we`=1, `ram_addr`=`spi_wr_addr`, `ram_wdata`=payload.
  - opcode 11: `ram_we`=0, `ram_addr`=`spi_rd_addr`.
  - In both cases `spi_pend` clears.
- ACC_HOST drives `ram_en`=1, `ram_we`=`host_we`, `ram_addr`=`host_addr`, `ram_wdata`=`host_wdata`, and `host_gnt`=1.
- RD_WAIT captures `ram_rdata` into `tx_data` (SPI read) or `host_rdata` (host read) and pulses the matching valid.
- RAM outputs are 0 whenever the FSM is not in an ACC state.
- Reset values:
  - All outputs 0.
  - Address registers, `spi_pend`, `spi_ovr` and the edge-detector register cleared.
  - FSM in IDLE.

## Timing
- SPI write: rising edge of `rx_valid` at cycle N; `spi_pend` set at N+1; RAM write at N+1 if uncontested, otherwise one host access later.
- SPI read: RAM read at cycle A; `tx_valid` pulse and `tx_data` update at A+1.
- Host: `host_gnt` appears no earlier than 1 cycle after `host_req` is sampled in IDLE. For reads, `host_rvalid` follows at gnt+1.
- Throughput: one RAM access per 1 cycle for writes and per 2 cycles for reads, plus one IDLE cycle per access.
- Worst-case SPI wait: one host access, guaranteed by round-robin.
- Simultaneous address load and pending read: an address-load capture updates the register even while an access is pending. An already-pending read uses the register value at its ACC cycle.
- `rst_n` asserted mid-access: all state clears immediately. An in-flight read produces no `tx_valid`/`host_rvalid`.

## Configuration
- `SPI_ADDR_AUTOINC_EN` defined:
  - `spi_wr_addr` increments after each opcode-01 write.
  - `spi_rd_addr` increments after each opcode-11 read.
  - Both wrap from `MEM_DEPTH`-1 to 0.
- Undefined: SPI address registers change only on opcodes 00/10.

## Structure
- Package `spi_ram_arb_pkg`:
  - state enum (IDLE, ACC_SPI, ACC_HOST, RD_WAIT).
  - opcode constants `OP_WR_ADDR`, `OP_WR_DATA`, `OP_RD_ADDR`, `OP_RD_DATA`.
  - requester id constants.
- Sub-module `rr_arb2`: 2-requester round-robin with `last_gnt` register. Inputs: `req[1:0]`, `advance`. Output: one-hot `gnt[1:0]`.

## Test plan
- SPI 0x005 (address 05), then 0x1A5 → single RAM write, address 05, data A5. No host activity.
- SPI 0x205, then 0x300 → RAM read at 05; `tx_valid` one cycle after `ram_en`, `tx_data`=A5.
- `host_req` read at 0x05 while SPI write-data is pending, both from reset → SPI wins. Host granted in the next arbitration cycle and returns A5 (or the newly written value if same address), `host_rvalid` pulse.
- `host_req` held continuously plus SPI read stream → accesses alternate host/SPI; SPI never waits more than one host access.
- Two `rx_valid` rising edges (0x111, 0x122) while host blocks the RAM → second word dropped, `spi_ovr`=1 sticky; RAM receives data 11 only.
- `SPI_ADDR_AUTOINC_EN`: write-address FF, then two writes 0x1AA and 0x1BB → RAM[FF]=AA, RAM[00]=BB. Also assert `rst_n` during RD_WAIT → no `tx_valid`, all outputs 0.
